// File: rtl/rtc_hms_param.sv
// Real-time clock core: prescaled 1 Hz tick driving a 24 h HH:MM:SS counter with
// time-set load, minute alarm, day-wrap pulse and 12/24 h seven-segment decode.
module rtc_hms_param #(
    parameter int CLK_DIV        = 100_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       load,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic [4:0] alm_hr,
    input  logic [5:0] alm_min,
    output logic [6:0] HR_M,
    output logic [6:0] HR_L,
    output logic [6:0] MIN_M,
    output logic [6:0] MIN_L,
    output logic [6:0] SEC_M,
    output logic [6:0] SEC_L,
    output logic       pm,
    output logic       alarm_hit,
    output logic       day_pulse,
    output logic       load_err
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [4:0]    hr_reg;
    logic [5:0]    min_reg;
    logic [5:0]    sec_reg;
    logic [PW-1:0] pcnt_reg;
    logic          alarm_hit_reg;
    logic          day_pulse_reg;
    logic          load_err_reg;

    logic [4:0] hr_next;
    logic [5:0] min_next;
    logic [5:0] sec_next;
    logic       day_wrap;
    logic       tick;
    logic       set_ok;
    logic       alarm_match;

    assign tick   = en && (pcnt_reg == PMAX);
    assign set_ok = (set_hr <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);

    // Time one second later, with the full sec -> min -> hr carry chain.
    always_comb begin
        sec_next = sec_reg + 6'd1;
        min_next = min_reg;
        hr_next  = hr_reg;
        day_wrap = 1'b0;
        if (sec_reg == 6'd59) begin
            sec_next = 6'd0;
            min_next = min_reg + 6'd1;
            if (min_reg == 6'd59) begin
                min_next = 6'd0;
                hr_next  = hr_reg + 5'd1;
                if (hr_reg == 5'd23) begin
                    hr_next  = 5'd0;
                    day_wrap = 1'b1;
                end
            end
        end
    end

    assign alarm_match = alarm_en && (sec_next == 6'd0) &&
                         (min_next == alm_min) && (hr_next == alm_hr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_reg        <= '0;
            min_reg       <= '0;
            sec_reg       <= '0;
            pcnt_reg      <= '0;
            alarm_hit_reg <= 1'b0;
            day_pulse_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            alarm_hit_reg <= 1'b0;
            day_pulse_reg <= 1'b0;
            load_err_reg  <= 1'b0;
            if (clr) begin
                hr_reg   <= '0;
                min_reg  <= '0;
                sec_reg  <= '0;
                pcnt_reg <= '0;
            end else if (load) begin
                // A load always wins over a coincident tick, accepted or not.
                if (set_ok) begin
                    hr_reg   <= set_hr;
                    min_reg  <= set_min;
                    sec_reg  <= set_sec;
                    pcnt_reg <= '0;
                end else begin
                    load_err_reg <= 1'b1;
                end
            end else if (tick) begin
                pcnt_reg      <= '0;
                hr_reg        <= hr_next;
                min_reg       <= min_next;
                sec_reg       <= sec_next;
                alarm_hit_reg <= alarm_match;
                day_pulse_reg <= day_wrap;
            end else if (en) begin
                pcnt_reg <= pcnt_reg + 1'b1;
            end
        end
    end

    assign alarm_hit = alarm_hit_reg;
    assign day_pulse = day_pulse_reg;
    assign load_err  = load_err_reg;
    assign pm        = (hr_reg >= 5'd12);

    // 12 h display: 0 -> 12, 13..23 -> 1..11, 1..12 unchanged.
    logic [4:0] disp_hr;
    always_comb begin
        disp_hr = hr_reg;
        if (mode_12h) begin
            if (hr_reg == 5'd0)
                disp_hr = 5'd12;
            else if (hr_reg > 5'd12)
                disp_hr = hr_reg - 5'd12;
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h7E;
            4'd1:    seg_code = 7'h30;
            4'd2:    seg_code = 7'h6D;
            4'd3:    seg_code = 7'h79;
            4'd4:    seg_code = 7'h33;
            4'd5:    seg_code = 7'h5B;
            4'd6:    seg_code = 7'h5F;
            4'd7:    seg_code = 7'h70;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h7B;
            default: seg_code = 7'h00;
        endcase
    endfunction

    logic [3:0] digit [6];
    logic [6:0] seg   [6];

    assign digit[0] = 4'(disp_hr / 5'd10);
    assign digit[1] = 4'(disp_hr % 5'd10);
    assign digit[2] = 4'(min_reg / 6'd10);
    assign digit[3] = 4'(min_reg % 6'd10);
    assign digit[4] = 4'(sec_reg / 6'd10);
    assign digit[5] = 4'(sec_reg % 6'd10);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_seg
            assign seg[gi] = seg_code(digit[gi]) ^ {7{SEG_ACTIVE_LOW}};
        end
    endgenerate

    assign HR_M  = seg[0];
    assign HR_L  = seg[1];
    assign MIN_M = seg[2];
    assign MIN_L = seg[3];
    assign SEC_M = seg[4];
    assign SEC_L = seg[5];
endmodule

// File: tb/tb_rtc_hms_param.sv
// Directed bench for rtc_hms_param with a 4-cycle prescaler: counting, carries,
// display modes, alarm, load errors, enable freeze and asynchronous reset.
module tb_rtc_hms_param;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       mode_12h;
    logic       alarm_en;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic [6:0] HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L;
    logic       pm, alarm_hit, day_pulse, load_err;

    int checks   = 0;
    int failures = 0;

    rtc_hms_param #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
        .mode_12h(mode_12h), .alarm_en(alarm_en), .alm_hr(alm_hr), .alm_min(alm_min),
        .HR_M(HR_M), .HR_L(HR_L), .MIN_M(MIN_M), .MIN_L(MIN_L), .SEC_M(SEC_M), .SEC_L(SEC_L),
        .pm(pm), .alarm_hit(alarm_hit), .day_pulse(day_pulse), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        load = 1'b1; set_hr = h; set_min = m; set_sec = s;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        set_hr = '0; set_min = '0; set_sec = '0;
        mode_12h = 1'b0; alarm_en = 1'b0; alm_hr = '0; alm_min = '0;

        // Reset state, both display modes
        #2;
        check("rst_hr_m", HR_M, 7'h7E);
        check("rst_sec_l", SEC_L, 7'h7E);
        check("rst_pm", {6'd0, pm}, 7'd0);
        check("rst_pulses", {4'd0, alarm_hit, day_pulse, load_err}, 7'd0);
        mode_12h = 1'b1; #1;
        check("rst_12h_hr_m", HR_M, 7'h30);
        check("rst_12h_hr_l", HR_L, 7'h6D);
        mode_12h = 1'b0;

        // First tick after CLK_DIV edges, then ten seconds
        step(1);
        rst_n = 1'b1; en = 1'b1;
        step(3);
        check("pre_tick_sec_l", SEC_L, 7'h7E);
        step(1);
        check("tick1_sec_l", SEC_L, 7'h30);
        step(36);
        check("sec10_sec_m", SEC_M, 7'h30);
        check("sec10_sec_l", SEC_L, 7'h7E);
        check("sec10_pm", {6'd0, pm}, 7'd0);

        // Day wrap
        do_load(5'd23, 6'd59, 6'd58);
        check("ld235958_hr_m", HR_M, 7'h6D);
        check("ld235958_hr_l", HR_L, 7'h79);
        check("ld235958_sec_l", SEC_L, 7'h7F);
        step(4);
        check("t235959_sec_l", SEC_L, 7'h7B);
        check("t235959_day", {6'd0, day_pulse}, 7'd0);
        step(4);
        check("wrap_hr_m", HR_M, 7'h7E);
        check("wrap_hr_l", HR_L, 7'h7E);
        check("wrap_min_m", MIN_M, 7'h7E);
        check("wrap_min_l", MIN_L, 7'h7E);
        check("wrap_sec_m", SEC_M, 7'h7E);
        check("wrap_sec_l", SEC_L, 7'h7E);
        check("wrap_day", {6'd0, day_pulse}, 7'd1);
        step(1);
        check("wrap_day_end", {6'd0, day_pulse}, 7'd0);

        // 12/24 h display
        mode_12h = 1'b1;
        do_load(5'd13, 6'd5, 6'd0);
        check("h13_12h_hr_m", HR_M, 7'h7E);
        check("h13_12h_hr_l", HR_L, 7'h30);
        check("h13_min_l", MIN_L, 7'h5B);
        check("h13_pm", {6'd0, pm}, 7'd1);
        do_load(5'd0, 6'd0, 6'd0);
        check("h0_12h_hr_m", HR_M, 7'h30);
        check("h0_12h_hr_l", HR_L, 7'h6D);
        check("h0_pm", {6'd0, pm}, 7'd0);
        mode_12h = 1'b0; #1;
        check("h0_24h_hr_m", HR_M, 7'h7E);
        check("h0_24h_hr_l", HR_L, 7'h7E);
        mode_12h = 1'b1;
        do_load(5'd12, 6'd0, 6'd0);
        check("h12_12h_hr_m", HR_M, 7'h30);
        check("h12_12h_hr_l", HR_L, 7'h6D);
        check("h12_pm", {6'd0, pm}, 7'd1);
        mode_12h = 1'b0;

        // Alarm
        alarm_en = 1'b1; alm_hr = 5'd7; alm_min = 6'd30;
        do_load(5'd7, 6'd29, 6'd59);
        step(3);
        check("alm_before", {6'd0, alarm_hit}, 7'd0);
        step(1);
        check("alm_hit", {6'd0, alarm_hit}, 7'd1);
        check("alm_min_m", MIN_M, 7'h79);
        check("alm_min_l", MIN_L, 7'h7E);
        step(1);
        check("alm_hit_end", {6'd0, alarm_hit}, 7'd0);
        alarm_en = 1'b0;
        do_load(5'd7, 6'd29, 6'd59);
        step(4);
        check("alm_dis_min_l", MIN_L, 7'h7E);
        check("alm_dis", {6'd0, alarm_hit}, 7'd0);
        alarm_en = 1'b1;
        do_load(5'd7, 6'd30, 6'd0);
        check("alm_load", {6'd0, alarm_hit}, 7'd0);

        // Rejected loads and clr priority
        do_load(5'd24, 6'd0, 6'd0);
        check("err_hr", {6'd0, load_err}, 7'd1);
        check("err_hr_keep_hr_l", HR_L, 7'h70);
        check("err_hr_keep_min_m", MIN_M, 7'h79);
        step(1);
        check("err_hr_end", {6'd0, load_err}, 7'd0);
        do_load(5'd0, 6'd60, 6'd0);
        check("err_min", {6'd0, load_err}, 7'd1);
        check("err_min_keep_hr_l", HR_L, 7'h70);
        clr = 1'b1;
        do_load(5'd12, 6'd34, 6'd56);
        clr = 1'b0;
        check("clr_ld_hr_l", HR_L, 7'h7E);
        check("clr_ld_min_l", MIN_L, 7'h7E);
        check("clr_ld_sec_l", SEC_L, 7'h7E);
        check("clr_ld_err", {6'd0, load_err}, 7'd0);

        // Enable freeze at pcnt=2
        step(2);
        en = 1'b0;
        step(10);
        check("frz_sec_l", SEC_L, 7'h7E);
        en = 1'b1;
        step(1);
        check("frz_resume1", SEC_L, 7'h7E);
        step(1);
        check("frz_resume2", SEC_L, 7'h30);

        // Asynchronous reset between edges discards a pending pulse
        do_load(5'd13, 6'd5, 6'd0);
        do_load(5'd24, 6'd0, 6'd0);
        check("pre_rst_err", {6'd0, load_err}, 7'd1);
        check("pre_rst_pm", {6'd0, pm}, 7'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_err", {6'd0, load_err}, 7'd0);
        check("arst_pm", {6'd0, pm}, 7'd0);
        check("arst_hr_l", HR_L, 7'h7E);
        check("arst_min_l", MIN_L, 7'h7E);
        rst_n = 1'b1;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
